// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter master port to synchronous single-port SRAM sequencer.
// Optional range check on accept: define MEMC_RANGE_CHK_EN.
module mem_ctrl #(
  parameter int AW     = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1,
  parameter int GAP    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   addr_m,
  input  logic [63:0]   dout_m,
  output logic [63:0]   din_m,
  input  logic          req_m,
  input  logic          wr_m,
  output logic          rdy_m,
  output logic          err_m,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic          mem_ce,
  output logic          mem_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  localparam logic [7:0] RD_L = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_L = 8'(WR_LAT - 1);
  localparam logic [7:0] GP_L = 8'(GAP - 1);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_wr;
  logic            r_bad;
  logic            r_err;
  logic            r_rdy;
  logic            r_ce;
  logic            r_we;
  logic [63:0]     r_din;
  logic [63:0]     r_wdata;
  logic [AW-1:0]   r_addr;

  logic            w_open;
  logic            w_bad;

  // Accept window: idle, last gap cycle, or done when there is no gap.
  always_comb begin
    w_open = 1'b0;
    if (r_state == S_IDLE)
      w_open = 1'b1;
    else if (r_state == S_GAP && r_cnt == 8'd0)
      w_open = 1'b1;
    else if (r_state == S_DONE && GAP == 0)
      w_open = 1'b1;
  end

`ifdef MEMC_RANGE_CHK_EN
  // Out-of-range high bits or a non word-aligned byte address.
  always_comb begin
    w_bad = (|addr_m[63:AW+3]) | (|addr_m[2:0]);
  end
`else
  logic w_unused;

  // Ignored address bits simply alias onto the word address.
  always_comb begin
    w_bad    = 1'b0;
    w_unused = ^{addr_m[63:AW+3], addr_m[2:0]};
  end
`endif

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_rdy   <= 1'b0;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_din   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
    end else begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_ACC: begin
          r_ce <= 1'b0;
          r_we <= 1'b0;
          if (r_bad) begin
            r_bad   <= 1'b0;
            r_din   <= '0;
            r_err   <= 1'b1;
            r_rdy   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_wr ? WR_L : RD_L;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_rdy   <= 1'b1;
            r_state <= S_DONE;
            if (!r_wr)
              r_din <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (GAP == 0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= GP_L;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == 8'd0)
            r_state <= S_IDLE;
          else
            r_cnt <= r_cnt - 8'd1;
        end
        default: ;
      endcase
      if (w_open && req_m) begin
        r_addr  <= addr_m[AW+2:3];
        r_wr    <= wr_m;
        r_wdata <= dout_m;
        r_bad   <= w_bad;
        r_ce    <= ~w_bad;
        r_we    <= wr_m & ~w_bad;
        r_state <= S_ACC;
      end
    end
  end

  assign din_m     = r_din;
  assign rdy_m     = r_rdy;
  assign err_m     = r_err;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_ce    = r_ce;
  assign mem_we    = r_we;

endmodule
